// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master: sequences START/addr/data/ACK/STOP on the
// data_clk phases from the SCL generator; SDA is driven open-drain.
module i2c_master_byte_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int SDA_SYNC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_clk,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              sda_in,
  output logic              busy,
  output logic [DATA_W-1:0] data_rd,
  output logic              rd_valid,
  output logic              ack_error,
  output logic              sda_oe,
  output logic              scl_not_ena
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    READY, START, COMMAND, SLV_ACK1, WR,
    RD, SLV_ACK2, MSTR_ACK, STOP
  } state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                sda_int_q, sda_int_d;
  logic                scl_ne_q, scl_ne_d;
  logic                ack_err_q, ack_err_d;
  logic [DATA_W-1:0]   data_rd_q, data_rd_d;
  logic                rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]     addr_rw_q, addr_rw_d;
  logic [DATA_W-1:0]   data_tx_q, data_tx_d;
  logic [DATA_W-1:0]   data_rx_q, data_rx_d;
  logic                dclk_prev_q;
  logic [SDA_SYNC-1:0] sync_q;

  logic             rise, fall, sda_s, match;
  logic [CNT_W-1:0] cnt_m1;

  assign rise   = data_clk & ~dclk_prev_q;
  assign fall   = ~data_clk & dclk_prev_q;
  assign sda_s  = sync_q[SDA_SYNC-1];
  assign match  = ena & ({addr, rw} == addr_rw_q);
  assign cnt_m1 = bit_cnt_q - CNT_W'(1);

  // dclk_prev tracks data_clk even in reset so release sees no edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= READY;
      busy_q      <= 1'b0;
      sda_int_q   <= 1'b1;
      scl_ne_q    <= 1'b1;
      ack_err_q   <= 1'b0;
      data_rd_q   <= '0;
      rd_vld_q    <= 1'b0;
      bit_cnt_q   <= CNT_MAX;
      addr_rw_q   <= '0;
      data_tx_q   <= '0;
      data_rx_q   <= '0;
      dclk_prev_q <= data_clk;
      sync_q      <= '1;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      sda_int_q   <= sda_int_d;
      scl_ne_q    <= scl_ne_d;
      ack_err_q   <= ack_err_d;
      data_rd_q   <= data_rd_d;
      rd_vld_q    <= rd_vld_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_rw_q   <= addr_rw_d;
      data_tx_q   <= data_tx_d;
      data_rx_q   <= data_rx_d;
      dclk_prev_q <= data_clk;
      sync_q      <= {sync_q[SDA_SYNC-2:0], sda_in};
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    sda_int_d = sda_int_q;
    scl_ne_d  = scl_ne_q;
    ack_err_d = ack_err_q;
    data_rd_d = data_rd_q;
    rd_vld_d  = 1'b0;
    bit_cnt_d = bit_cnt_q;
    addr_rw_d = addr_rw_q;
    data_tx_d = data_tx_q;
    data_rx_d = data_rx_q;
    if (rise) begin
      unique case (state_q)
        READY: begin
          if (ena) begin
            addr_rw_d = {addr, rw};
            data_tx_d = data_wr;
            busy_d    = 1'b1;
            sda_int_d = 1'b0;
            state_d   = START;
          end else begin
            busy_d = 1'b0;
          end
        end
        START: begin
          sda_int_d = addr_rw_q[ADDR_W];
          bit_cnt_d = CNT_MAX;
          state_d   = COMMAND;
        end
        COMMAND: begin
          if (bit_cnt_q == '0) begin
            sda_int_d = 1'b1;
            bit_cnt_d = CNT_MAX;
            state_d   = SLV_ACK1;
          end else begin
            bit_cnt_d = cnt_m1;
            sda_int_d = addr_rw_q[cnt_m1];
          end
        end
        SLV_ACK1: begin
          if (!addr_rw_q[0]) begin
            sda_int_d = data_tx_q[DATA_W-1];
            state_d   = WR;
          end else begin
            sda_int_d = 1'b1;
            state_d   = RD;
          end
        end
        WR: begin
          busy_d = 1'b1;
          if (bit_cnt_q == '0) begin
            sda_int_d = 1'b1;
            bit_cnt_d = CNT_MAX;
            state_d   = SLV_ACK2;
          end else begin
            bit_cnt_d = cnt_m1;
            sda_int_d = data_tx_q[cnt_m1];
          end
        end
        RD: begin
          busy_d = 1'b1;
          if (bit_cnt_q == '0) begin
            data_rd_d = data_rx_q;
            rd_vld_d  = 1'b1;
            sda_int_d = ~match;
            bit_cnt_d = CNT_MAX;
            state_d   = MSTR_ACK;
          end else begin
            bit_cnt_d = cnt_m1;
          end
        end
        SLV_ACK2: begin
          if (match) begin
            busy_d    = 1'b0;
            data_tx_d = data_wr;
            sda_int_d = data_wr[DATA_W-1];
            state_d   = WR;
          end else begin
            sda_int_d = 1'b0;
            state_d   = STOP;
          end
        end
        MSTR_ACK: begin
          if (match) begin
            busy_d    = 1'b0;
            sda_int_d = 1'b1;
            state_d   = RD;
          end else begin
            sda_int_d = 1'b0;
            state_d   = STOP;
          end
        end
        STOP: begin
          sda_int_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = READY;
        end
        default: state_d = READY;
      endcase
    end else if (fall) begin
      case (state_q)
        START: begin
          scl_ne_d  = 1'b0;
          ack_err_d = 1'b0;
        end
        SLV_ACK1, SLV_ACK2: ack_err_d = ack_err_q | sda_s;
        RD:      data_rx_d[bit_cnt_q] = sda_s;
        STOP:    scl_ne_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = busy_q;
    data_rd     = data_rd_q;
    rd_valid    = rd_vld_q;
    ack_error   = ack_err_q;
    sda_oe      = ~sda_int_q;
    scl_not_ena = scl_ne_q;
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
Name: i2c_master_byte_ctrl

Overview:
- Byte-level I2C master controller, directly downstream of the SCL timing/stretch generator.
- Consumes that generator's data_clk phase signal and returns scl_not_ena to it, which gates SCL.
- Sequences START, 7-bit address + R/W, slave ACK, write/read data bytes, master ACK/NACK and STOP, driving SDA open-drain.
- Presents a busy/ena command handshake to the host logic.

Parameters:
- ADDR_W, 7, slave address width (fixed I2C 7-bit addressing).
- DATA_W, 8, data byte width.
- SDA_SYNC, 2, flop stages synchronising sda_in before use (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_clk  in  1  data-phase clock from the SCL generator. Rising edge = SDA update point; falling edge = SDA sample point.
- ena  in  1  host request: start a transaction or continue with the next byte.
- addr  in  ADDR_W  slave address.
- rw  in  1  0 = write, 1 = read.
- data_wr  in  DATA_W  byte to transmit.
- sda_in  in  1  bus SDA level (asynchronous).
- busy  out  1  1 while a byte is in progress. A 1->0 transition means the command was latched and the next command may be presented.
- data_rd  out  DATA_W  last received byte.
- rd_valid  out  1  1-cycle pulse when data_rd updates.
- ack_error  out  1  sticky: a slave NACK occurred in the current transaction.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- scl_not_ena  out  1  to SCL generator: 1 = SCL held released/high; 0 = SCL toggling.

Behaviour:
- Reset values:
  - state=READY, busy=0, sda_int=1 (sda_oe=0), scl_not_ena=1, ack_error=0, data_rd=0, rd_valid=0, bit_cnt=7.
  - During reset, dclk_prev<=data_clk, so no spurious edge is seen on release.
- Reset mid-transaction: the bus is released on the next clk (sda_oe=0, scl_not_ena=1). No STOP is generated.
- Edge detect: rise = data_clk & ~dclk_prev; fall = ~data_clk & dclk_prev.
  - All state/SDA changes happen on rise. All sampling and the scl_not_ena update happen on fall.
  - At most one action per clk. With data_clk frozen (stretch), all state holds.
- sda_oe = ~sda_int, registered. sda_s = synchronised sda_in.
- The {addr,rw} and data_wr latches are captured only when the command is accepted.
- Rise actions per state:
  - READY:
    - ena=1: latch {addr,rw}->addr_rw and data_wr->data_tx; busy=1; sda_int=0 (START, SCL still high); ->START.
    - Else busy=0.
  - START: sda_int=addr_rw[7]; bit_cnt=7; ->COMMAND.
  - COMMAND:
    - bit_cnt==0: sda_int=1; bit_cnt=7; ->SLV_ACK1.
    - Else bit_cnt--; sda_int=addr_rw[bit_cnt-1].
  - SLV_ACK1:
    - rw=0: sda_int=data_tx[7]; ->WR.
    - rw=1: sda_int=1; ->RD.
  - WR:
    - bit_cnt==0: sda_int=1; bit_cnt=7; ->SLV_ACK2.
    - Else bit_cnt--; sda_int=data_tx[bit_cnt-1].
  - RD:
    - bit_cnt==0:
      - data_rd=data_rx; rd_valid=1.
      - sda_int=0 (ACK) if ena=1 and {addr,rw}==addr_rw; else sda_int=1 (NACK).
      - bit_cnt=7; ->MSTR_ACK.
    - Else bit_cnt--.
  - SLV_ACK2:
    - ena=1 and {addr,rw}==addr_rw: busy=0; latch data_wr; sda_int=data_wr[7]; ->WR.
    - Else sda_int=0; ->STOP.
  - MSTR_ACK:
    - ena=1 and match: busy=0; sda_int=1; ->RD.
    - Else sda_int=0; ->STOP.
  - STOP: sda_int=1 (STOP: SDA rises while SCL high); busy=0; ->READY.
- Fall actions per state:
  - START: scl_not_ena=0; ack_error=0.
  - SLV_ACK1, SLV_ACK2: ack_error |= sda_s.
  - RD: data_rx[bit_cnt]=sda_s.
  - STOP: scl_not_ena=1.
  - All other states: no action.
- busy returns to 1 on the next rise after acceptance (WR/RD).
- busy stays 0 from STOP until the next accepted command.
- Address NACK: ack_error=1, and the transfer continues until the host drops ena or changes address.
- Address/rw change with ena=1 at an ACK point: STOP is issued, then a new START from READY. No repeated START.

Test Plan:
- Write: addr=0x50, rw=0, data_wr=0xA5, slave ACKs, ena dropped after busy falls -> SDA bits on rise: START, 1010000, 0, release, 10100101, release, STOP; ack_error=0; final busy=0, scl_not_ena=1.
- Read: addr=0x50, rw=1, slave drives 0x3C, ena dropped during byte -> data_rd=0x3C, rd_valid high exactly 1 clk, master NACK (sda_oe=0 in MSTR_ACK), STOP.
- Address NACK: sda_in held 1 in SLV_ACK1 -> ack_error=1 after that fall, stays 1 until the next START fall.
- Multi-byte write 0x11,0x22 same address, ena held -> no STOP between bytes, busy falls once per byte, second byte bits 00100010.
- Stretch: data_clk frozen 500 clks mid-WR -> sda_oe, state and bit_cnt unchanged; resumes correctly.
- Reset asserted mid-RD -> next clk sda_oe=0, scl_not_ena=1, busy=0, state READY; a new transaction afterwards completes.
